// File: rtl/nic_pkt_engine_if.sv
// NIC processor-side register port: one access strobe, write enable,
// 2-bit register address, 64-bit write data and 64-bit read data.
interface nic_pkt_engine_if;
    logic        nicEn;
    logic        nicWrEn;
    logic [1:0]  addr_nic;
    logic [63:0] din_nic;
    logic [63:0] dout_nic;

    // The engine drives the access; the NIC answers on dout_nic.
    modport master (
        output nicEn,
        output nicWrEn,
        output addr_nic,
        output din_nic,
        input  dout_nic
    );

    modport slave (
        input  nicEn,
        input  nicWrEn,
        input  addr_nic,
        input  din_nic,
        output dout_nic
    );
endinterface

// File: rtl/nic_pkt_engine.sv
// NIC packet engine: polls NIC status registers, injects a programmed number
// of packets and drains a programmed number of received packets, interleaving
// the two directions. All outputs, including the NIC strobes, are registered.
module nic_pkt_engine #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] SEQ_INIT = 32'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     tx_num,
    input  logic [CNT_W-1:0]     rx_num,
    input  logic [31:0]          tx_hdr,
    nic_pkt_engine_if.master     nic,
    output logic                 busy,
    output logic                 done,
    output logic                 rx_valid,
    output logic [63:0]          rx_data,
    output logic [CNT_W-1:0]     tx_cnt,
    output logic [CNT_W-1:0]     rx_cnt,
    output logic [63:0]          rx_xor
);

    typedef enum logic [3:0] {
        IDLE, TX_STAT, TX_CHK, TX_WR, RX_STAT, RX_CHK, RX_RD, RX_CAP, DONE
    } state_t;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] tx_num_q;
    logic [CNT_W-1:0] rx_num_q;
    logic [31:0]      hdr_q;
    logic [31:0]      seq;
    logic [CNT_W-1:0] tx_cnt_nx;
    logic [CNT_W-1:0] rx_cnt_nx;
    logic             tx_more;
    logic             rx_more;

    // States that place an access on the NIC port for their whole cycle.
    function automatic logic is_access(state_t s);
        return (s == TX_STAT) || (s == TX_WR) || (s == RX_STAT) || (s == RX_RD);
    endfunction

    function automatic logic [1:0] addr_for(state_t s);
        case (s)
            TX_STAT: return ADDR_OUT_STAT;
            TX_WR:   return ADDR_OUT_BUF;
            RX_STAT: return ADDR_IN_STAT;
            default: return ADDR_IN_BUF;
        endcase
    endfunction

    // Next-state selection; remaining-work flags already account for the
    // packet being completed in TX_WR / RX_CAP this cycle.
    always_comb begin
        tx_cnt_nx = tx_cnt + CNT_W'(state == TX_WR);
        rx_cnt_nx = rx_cnt + CNT_W'(state == RX_CAP);
        tx_more   = (state == IDLE) ? (tx_num != '0) : (tx_cnt_nx < tx_num_q);
        rx_more   = (state == IDLE) ? (rx_num != '0) : (rx_cnt_nx < rx_num_q);
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = tx_more ? TX_STAT : (rx_more ? RX_STAT : DONE);
            TX_STAT: state_nxt = TX_CHK;
            TX_CHK:  state_nxt = !nic.dout_nic[63] ? TX_WR : (rx_more ? RX_STAT : TX_STAT);
            TX_WR:   state_nxt = rx_more ? RX_STAT : (tx_more ? TX_STAT : DONE);
            RX_STAT: state_nxt = RX_CHK;
            RX_CHK:  state_nxt = nic.dout_nic[63] ? RX_RD : (tx_more ? TX_STAT : RX_STAT);
            RX_RD:   state_nxt = RX_CAP;
            RX_CAP:  state_nxt = tx_more ? TX_STAT : (rx_more ? RX_STAT : DONE);
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register, NIC strobes for the state being entered, and the
    // per-state bookkeeping performed at the end of each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            nic.nicEn    <= 1'b0;
            nic.nicWrEn  <= 1'b0;
            nic.addr_nic <= '0;
            nic.din_nic  <= '0;
            tx_num_q     <= '0;
            rx_num_q     <= '0;
            hdr_q        <= '0;
            seq          <= SEQ_INIT;
            busy         <= 1'b0;
            done         <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            tx_cnt       <= '0;
            rx_cnt       <= '0;
            rx_xor       <= '0;
        end else begin
            state        <= state_nxt;
            nic.nicEn    <= is_access(state_nxt);
            nic.nicWrEn  <= (state_nxt == TX_WR);
            nic.addr_nic <= is_access(state_nxt) ? addr_for(state_nxt) : 2'b00;
            nic.din_nic  <= (state_nxt == TX_WR) ? {hdr_q, seq} : 64'd0;
            done         <= 1'b0;
            rx_valid     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_num_q <= tx_num;
                        rx_num_q <= rx_num;
                        hdr_q    <= tx_hdr;
                        tx_cnt   <= '0;
                        rx_cnt   <= '0;
                        rx_xor   <= '0;
                        busy     <= 1'b1;
                    end
                end
                TX_WR: begin
                    seq    <= seq + 32'd1;
                    tx_cnt <= tx_cnt_nx;
                end
                RX_CAP: begin
                    rx_data  <= nic.dout_nic;
                    rx_xor   <= rx_xor ^ nic.dout_nic;
                    rx_cnt   <= rx_cnt_nx;
                    rx_valid <= 1'b1;
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
